// File: rtl/osd_pkg.sv
// Shared types for the OSD character writer: command opcodes, FSM states and
// the default blank character used by CLEAR.
package osd_pkg;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_CLEAR  = 3'd1,
        OP_SETPOS = 3'd2,
        OP_PUTC   = 3'd3,
        OP_PUTHEX = 3'd4
    } osd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_HEX_LO = 2'd2
    } osd_state_e;

    localparam logic [7:0] BLANK_CHAR_DEFAULT = 8'h20;

endpackage

// File: rtl/osd_hex_ascii.sv
// Combinational nibble to uppercase ASCII hex digit converter.
module osd_hex_ascii (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    logic [7:0] w_nibbleWide;

    assign w_nibbleWide = {4'h0, i_nibble};

    // 'A' - 10 = 8'h37, so letters land on 8'h41..8'h46
    assign o_ascii = (i_nibble < 4'd10) ? (8'h30 + w_nibbleWide)
                                        : (8'h37 + w_nibbleWide);

endmodule

// File: rtl/osd_char_writer.sv
// Command-driven writer for the OSD overlay character RAM: clear, cursor
// positioning, character and hex-byte output with registered RAM write port.
module osd_char_writer
    import osd_pkg::*;
#(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 30,
    parameter logic [7:0] BLANK_CHAR = BLANK_CHAR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    input  logic [5:0]  cmd_col,
    input  logic [4:0]  cmd_row,
    output logic [10:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic [5:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic        pos_err
);

    localparam logic [6:0]  COLS_LIM = 7'(COLS);
    localparam logic [5:0]  ROWS_LIM = 6'(ROWS);
    localparam logic [5:0]  LAST_COL = 6'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
    localparam logic [10:0] COLS_A   = 11'(COLS);
    localparam logic [11:0] TOTAL    = 12'(COLS * ROWS);

    osd_state_e  r_state;
    osd_state_e  w_nextState;

    logic [5:0]  r_curCol, w_nextCol, w_advCol;
    logic [4:0]  r_curRow, w_nextRow, w_advRow;
    logic [11:0] r_clrCnt, w_nextClrCnt;
    logic [3:0]  r_hexLo, w_nextHexLo;
    logic [10:0] r_wrAddr, w_nextWrAddr;
    logic [7:0]  r_wrData, w_nextWrData;
    logic        r_wrEn, w_nextWrEn;
    logic        r_posErr, w_nextPosErr;

    logic [10:0] w_curAddr;
    logic [3:0]  w_nibble;
    logic [7:0]  w_hexAscii;
    logic        w_posOk;

    assign w_curAddr = (11'(r_curRow) * COLS_A) + 11'(r_curCol);
    assign w_posOk   = ({1'b0, cmd_col} < COLS_LIM) && ({1'b0, cmd_row} < ROWS_LIM);
    assign w_nibble  = (r_state == ST_HEX_LO) ? r_hexLo : cmd_data[7:4];

    // Raster-order advance with wrap from the bottom-right cell back to the top.
    always_comb begin
        w_advCol = r_curCol + 6'd1;
        w_advRow = r_curRow;
        if (r_curCol == LAST_COL) begin
            w_advCol = 6'd0;
            w_advRow = (r_curRow == LAST_ROW) ? 5'd0 : (r_curRow + 5'd1);
        end
    end

    osd_hex_ascii u_hexAscii (
        .i_nibble (w_nibble),
        .o_ascii  (w_hexAscii)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and next-register logic; every write is staged here so the
    // RAM port registers present it one cycle after the command is accepted.
    always_comb begin
        w_nextState  = r_state;
        w_nextCol    = r_curCol;
        w_nextRow    = r_curRow;
        w_nextClrCnt = r_clrCnt;
        w_nextHexLo  = r_hexLo;
        w_nextWrEn   = 1'b0;
        w_nextWrAddr = r_wrAddr;
        w_nextWrData = r_wrData;
        w_nextPosErr = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (osd_op_e'(cmd_op))
                        OP_CLEAR: begin
                            w_nextWrEn   = 1'b1;
                            w_nextWrAddr = 11'd0;
                            w_nextWrData = BLANK_CHAR;
                            w_nextClrCnt = 12'd1;
                            w_nextState  = ST_CLEAR;
                        end
                        OP_SETPOS: begin
                            if (w_posOk) begin
                                w_nextCol = cmd_col;
                                w_nextRow = cmd_row;
                            end else begin
                                w_nextPosErr = 1'b1;
                            end
                        end
                        OP_PUTC: begin
                            w_nextWrEn   = 1'b1;
                            w_nextWrAddr = w_curAddr;
                            w_nextWrData = cmd_data;
                            w_nextCol    = w_advCol;
                            w_nextRow    = w_advRow;
                        end
                        OP_PUTHEX: begin
                            w_nextWrEn   = 1'b1;
                            w_nextWrAddr = w_curAddr;
                            w_nextWrData = w_hexAscii;
                            w_nextCol    = w_advCol;
                            w_nextRow    = w_advRow;
                            w_nextHexLo  = cmd_data[3:0];
                            w_nextState  = ST_HEX_LO;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            ST_CLEAR: begin
                // One idle cycle after the last write before returning to IDLE.
                if (r_clrCnt < TOTAL) begin
                    w_nextWrEn   = 1'b1;
                    w_nextWrAddr = r_clrCnt[10:0];
                    w_nextWrData = BLANK_CHAR;
                    w_nextClrCnt = r_clrCnt + 12'd1;
                end else begin
                    w_nextCol   = 6'd0;
                    w_nextRow   = 5'd0;
                    w_nextState = ST_IDLE;
                end
            end
            ST_HEX_LO: begin
                w_nextWrEn   = 1'b1;
                w_nextWrAddr = w_curAddr;
                w_nextWrData = w_hexAscii;
                w_nextCol    = w_advCol;
                w_nextRow    = w_advRow;
                w_nextState  = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_curCol <= 6'd0;
            r_curRow <= 5'd0;
            r_clrCnt <= 12'd0;
            r_hexLo  <= 4'd0;
            r_wrAddr <= 11'd0;
            r_wrData <= 8'd0;
            r_wrEn   <= 1'b0;
            r_posErr <= 1'b0;
        end else begin
            r_curCol <= w_nextCol;
            r_curRow <= w_nextRow;
            r_clrCnt <= w_nextClrCnt;
            r_hexLo  <= w_nextHexLo;
            r_wrAddr <= w_nextWrAddr;
            r_wrData <= w_nextWrData;
            r_wrEn   <= w_nextWrEn;
            r_posErr <= w_nextPosErr;
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign wr_addr   = r_wrAddr;
    assign wr_data   = r_wrData;
    assign wr_en     = r_wrEn;
    assign cur_col   = r_curCol;
    assign cur_row   = r_curRow;
    assign pos_err   = r_posErr;

endmodule

// File: tb/tb_osd_char_writer.sv
// Scoreboard testbench for osd_char_writer: expected RAM writes are queued as
// commands are driven and checked as the write port produces them.
module tb_osd_char_writer;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op    = 3'd0;
    logic [7:0]  cmd_data  = 8'd0;
    logic [5:0]  cmd_col   = 6'd0;
    logic [4:0]  cmd_row   = 5'd0;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic [5:0]  cur_col;
    logic [4:0]  cur_row;
    logic        pos_err;

    int vectors     = 0;
    int miscompares = 0;
    int wrCount     = 0;

    logic [18:0] expQ[$];

    osd_char_writer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_col   (cmd_col),
        .cmd_row   (cmd_row),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .cur_col   (cur_col),
        .cur_row   (cur_row),
        .pos_err   (pos_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    // Write-port monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [18:0] expEntry;
        if (wr_en === 1'b1) begin
            wrCount++;
            vectors++;
            if (expQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_write actual addr=%0d data=%02h required=none", wr_addr, wr_data);
            end else begin
                expEntry = expQ.pop_front();
                if ({wr_addr, wr_data} !== expEntry) begin
                    miscompares++;
                    $display("[TB] FAIL write actual addr=%0d data=%02h required addr=%0d data=%02h",
                             wr_addr, wr_data, expEntry[18:8], expEntry[7:0]);
                end
            end
        end
    end

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        logic [7:0] c;
        if (n < 4'd10) c = 8'h30 + {4'h0, n};
        else           c = 8'h41 + ({4'h0, n} - 8'd10);
        return c;
    endfunction

    task automatic pushWrite(input int addr, input logic [7:0] data);
        expQ.push_back({11'(addr), data});
    endtask

    task automatic driveCmd(input logic [2:0] op, input logic [7:0] data,
                            input logic [5:0] col, input logic [4:0] row);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_col   = col;
        cmd_row   = row;
    endtask

    task automatic sendCmd(input logic [2:0] op, input logic [7:0] data,
                           input logic [5:0] col, input logic [4:0] row);
        @(negedge clk);
        driveCmd(op, data, col, row);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready actual=%b required=1", cmd_ready); end
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_en actual=%b required=0", wr_en); end
        vectors++; if (wr_addr !== 11'd0) begin miscompares++; $display("[TB] FAIL reset_wr_addr actual=%0d required=0", wr_addr); end
        vectors++; if (wr_data !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_wr_data actual=%02h required=00", wr_data); end
        vectors++; if ({cur_col, cur_row} !== 11'd0) begin miscompares++; $display("[TB] FAIL reset_cursor actual=(%0d,%0d) required=(0,0)", cur_col, cur_row); end
        vectors++; if (pos_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pos_err actual=%b required=0", pos_err); end
    endtask

    task automatic test_clear();
        int startCount;
        int cyc;
        sendCmd(3'd2, 8'd0, 6'd7, 5'd3);
        vectors++; if ({cur_col, cur_row} !== {6'd7, 5'd3}) begin miscompares++; $display("[TB] FAIL setpos_7_3 actual=(%0d,%0d) required=(7,3)", cur_col, cur_row); end
        for (int a = 0; a < 1200; a++) pushWrite(a, 8'h20);
        startCount = wrCount;
        sendCmd(3'd1, 8'd0, 6'd0, 5'd0);
        cyc = 1;
        while (cmd_ready !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        vectors++; if (cyc != 1201) begin miscompares++; $display("[TB] FAIL clear_ready_cycle actual=%0d required=1201", cyc); end
        @(negedge clk);
        vectors++; if (wrCount - startCount != 1200) begin miscompares++; $display("[TB] FAIL clear_write_count actual=%0d required=1200", wrCount - startCount); end
        vectors++; if (expQ.size() != 0) begin miscompares++; $display("[TB] FAIL clear_pending actual=%0d required=0", expQ.size()); end
        vectors++; if ({cur_col, cur_row} !== 11'd0) begin miscompares++; $display("[TB] FAIL clear_cursor actual=(%0d,%0d) required=(0,0)", cur_col, cur_row); end
    endtask

    task automatic test_putc_back_to_back();
        sendCmd(3'd2, 8'd0, 6'd39, 5'd0);
        vectors++; if (pos_err !== 1'b0) begin miscompares++; $display("[TB] FAIL setpos_39_0_err actual=%b required=0", pos_err); end
        pushWrite(39, 8'h41);
        pushWrite(40, 8'h42);
        @(negedge clk);
        driveCmd(3'd3, 8'h41, 6'd0, 5'd0);
        @(negedge clk);
        driveCmd(3'd3, 8'h42, 6'd0, 5'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        vectors++; if ({cur_col, cur_row} !== {6'd1, 5'd1}) begin miscompares++; $display("[TB] FAIL putc_cursor actual=(%0d,%0d) required=(1,1)", cur_col, cur_row); end
        sendCmd(3'd6, 8'h55, 6'd9, 5'd9);
        vectors++; if ({cur_col, cur_row} !== {6'd1, 5'd1}) begin miscompares++; $display("[TB] FAIL nop6_cursor actual=(%0d,%0d) required=(1,1)", cur_col, cur_row); end
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL nop6_ready actual=%b required=1", cmd_ready); end
    endtask

    task automatic test_wrap();
        sendCmd(3'd2, 8'd0, 6'd39, 5'd29);
        vectors++; if ({cur_col, cur_row} !== {6'd39, 5'd29}) begin miscompares++; $display("[TB] FAIL setpos_last actual=(%0d,%0d) required=(39,29)", cur_col, cur_row); end
        pushWrite(1199, 8'h58);
        sendCmd(3'd3, 8'h58, 6'd0, 5'd0);
        vectors++; if ({cur_col, cur_row} !== 11'd0) begin miscompares++; $display("[TB] FAIL wrap_cursor actual=(%0d,%0d) required=(0,0)", cur_col, cur_row); end
    endtask

    task automatic test_puthex();
        logic [7:0] bytes[2];
        bytes[0] = 8'h3F;
        bytes[1] = 8'hA9;
        sendCmd(3'd2, 8'd0, 6'd5, 5'd2);
        for (int i = 0; i < 2; i++) begin
            pushWrite(85 + 2 * i, hexChar(bytes[i][7:4]));
            pushWrite(86 + 2 * i, hexChar(bytes[i][3:0]));
            @(negedge clk);
            driveCmd(3'd4, bytes[i], 6'd0, 5'd0);
            @(negedge clk);
            driveCmd(3'd3, 8'h5A, 6'd0, 5'd0);
            vectors++; if (cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL puthex_busy actual=%b required=0", cmd_ready); end
            @(negedge clk);
            cmd_valid = 1'b0;
            cmd_op    = 3'd0;
            vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL puthex_done actual=%b required=1", cmd_ready); end
            vectors++; if ({cur_col, cur_row} !== {6'(7 + 2 * i), 5'd2}) begin miscompares++; $display("[TB] FAIL puthex_cursor actual=(%0d,%0d) required=(%0d,2)", cur_col, cur_row, 7 + 2 * i); end
        end
    endtask

    task automatic test_pos_err();
        logic [5:0] badCol[2];
        logic [4:0] badRow[2];
        badCol[0] = 6'd40; badRow[0] = 5'd3;
        badCol[1] = 6'd0;  badRow[1] = 5'd30;
        sendCmd(3'd2, 8'd0, 6'd10, 5'd4);
        for (int i = 0; i < 2; i++) begin
            sendCmd(3'd2, 8'd0, badCol[i], badRow[i]);
            vectors++; if (pos_err !== 1'b1) begin miscompares++; $display("[TB] FAIL pos_err_pulse actual=%b required=1", pos_err); end
            vectors++; if ({cur_col, cur_row} !== {6'd10, 5'd4}) begin miscompares++; $display("[TB] FAIL pos_err_cursor actual=(%0d,%0d) required=(10,4)", cur_col, cur_row); end
            @(negedge clk);
            vectors++; if (pos_err !== 1'b0) begin miscompares++; $display("[TB] FAIL pos_err_width actual=%b required=0", pos_err); end
        end
    endtask

    task automatic test_reset_abort();
        int startCount;
        sendCmd(3'd2, 8'd0, 6'd3, 5'd3);
        for (int a = 0; a <= 500; a++) pushWrite(a, 8'h20);
        startCount = wrCount;
        sendCmd(3'd1, 8'd0, 6'd0, 5'd0);
        repeat (500) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_wr_en actual=%b required=0", wr_en); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_ready actual=%b required=1", cmd_ready); end
        vectors++; if ({cur_col, cur_row} !== 11'd0) begin miscompares++; $display("[TB] FAIL abort_cursor actual=(%0d,%0d) required=(0,0)", cur_col, cur_row); end
        repeat (5) @(negedge clk);
        vectors++; if (wrCount - startCount != 501) begin miscompares++; $display("[TB] FAIL abort_write_count actual=%0d required=501", wrCount - startCount); end
    endtask

    initial begin
        $display("[TB] osd_char_writer bench start");
        test_reset();
        test_clear();
        test_putc_back_to_back();
        test_wrap();
        test_puthex();
        test_pos_err();
        test_reset_abort();
        repeat (3) @(negedge clk);
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL pending_writes actual=%0d required=0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/osd_char_writer.md
OSD_CHAR_WRITER -- requirements
Module: osd_char_writer

Interface
REQ-001 SHALL have parameter COLS, default 40, character columns per screen.
REQ-002 SHALL have parameter ROWS, default 30, character rows per screen.
REQ-003 SHALL have parameter BLANK_CHAR, default 8'h20, code written by CLEAR.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-008 SHALL have port cmd_op  input  3  opcode: 0 NOP, 1 CLEAR, 2 SETPOS, 3 PUTC, 4 PUTHEX; 5-7 treated as NOP.
REQ-009 SHALL have port cmd_data  input  8  character code (PUTC) or byte value (PUTHEX).
REQ-010 SHALL have port cmd_col  input  6  target column (SETPOS).
REQ-011 SHALL have port cmd_row  input  5  target row (SETPOS).
REQ-012 SHALL have port wr_addr  output  11  char RAM write address, row*COLS+col.
REQ-013 SHALL have port wr_data  output  8  char RAM write data.
REQ-014 SHALL have port wr_en  output  1  single-cycle char RAM write strobe.
REQ-015 SHALL have port cur_col  output  6  current cursor column.
REQ-016 SHALL have port cur_row  output  5  current cursor row.
REQ-017 SHALL have port pos_err  output  1  one-cycle pulse on rejected SETPOS.

Function
REQ-018 SHALL implement FSM states IDLE, CLEAR, HEX_LO; cmd_ready SHALL be 1 only in IDLE.
REQ-019 SHALL register wr_addr/wr_data/wr_en; write caused by command accepted in cycle N SHALL appear in cycle N+1.
REQ-020 SHALL hold wr_en low in every cycle not carrying a write; wr_addr/wr_data hold last value.
REQ-021 CLEAR SHALL write BLANK_CHAR to addresses 0..COLS*ROWS-1 ascending, one per cycle, consecutive cycles, then return to IDLE and set cursor to (0,0).
REQ-022 CLEAR SHALL keep cmd_ready low from acceptance until the cycle after the last write (1199 for defaults).
REQ-023 SETPOS SHALL load cursor from cmd_col/cmd_row when col<COLS and row<ROWS, no write, stay IDLE.
REQ-024 SETPOS out of range SHALL leave cursor unchanged and pulse pos_err for one cycle (cycle N+1).
REQ-025 PUTC SHALL write cmd_data at cursor, then advance cursor.
REQ-026 Cursor advance: col+1; at col==COLS-1 col->0 and row+1; at row==ROWS-1 row->0 (wrap to top).
REQ-027 PUTHEX SHALL write ASCII of cmd_data[7:4] at cursor, advance, enter HEX_LO, write ASCII of cmd_data[3:0] next cycle, advance, return IDLE.
REQ-028 Hex nibbles 0-9 SHALL map to 8'h30-8'h39, A-F to 8'h41-8'h46 (uppercase).
REQ-029 Address SHALL be computed 11-bit unsigned from registered cursor; no overflow for COLS*ROWS<=2048.
REQ-030 NOP and opcodes 5-7 SHALL be accepted with no write and no cursor change.
REQ-031 cmd_* inputs SHALL be ignored while cmd_ready is low.

Reset
REQ-032 On reset_n low at a clock edge: state IDLE, cursor (0,0), wr_en 0, wr_addr 0, wr_data 0, pos_err 0; cmd_ready 1 from the first cycle after release.
REQ-033 Reset during CLEAR or HEX_LO SHALL abort immediately; no further writes issued.

Structure
REQ-034 Opcode enum, state enum, and BLANK_CHAR default SHALL live in shared package osd_pkg.
REQ-035 Nibble-to-ASCII conversion SHALL be sub-module osd_hex_ascii (combinational, 4-in/8-out).
REQ-036 Outputs wr_addr/wr_data/wr_en SHALL connect directly to the OSD overlay char RAM write port without glue.

Verification
REQ-037 Reset, CLEAR -> exactly 1200 wr_en pulses, addr 0..1199 contiguous, data 8'h20, cmd_ready high in cycle 1201 after acceptance.
REQ-038 SETPOS(39,0), PUTC 8'h41, PUTC 8'h42 -> writes addr 39 data 8'h41, addr 40 data 8'h42; cursor (1,1).
REQ-039 SETPOS(39,29), PUTC 8'h58 -> write addr 1199; cursor wraps to (0,0).
REQ-040 SETPOS(5,2), PUTHEX 8'h3F -> addr 85 data 8'h33, next cycle addr 86 data 8'h46; cmd_ready low exactly one cycle.
REQ-041 SETPOS(40,3) and SETPOS(0,30) -> pos_err pulse each, no write, cursor unchanged.
REQ-042 Reset_n low at CLEAR write 500 -> wr_en low next cycle, no further writes, cursor (0,0), cmd_ready high after release.
